// File: rtl/decode_pipe_stage_pkg.sv
// decode_pkg: shared constants and helpers for the RV32I decode stage.
//   - base opcode encodings
//   - immediate format selector (imm_sel_e)
//   - ALU control codes and write-back source codes
//   - gen_imm: builds the sign-extended immediate for a format
//   - alu_from_funct3: maps funct3 (+ alternate bit) to an ALU code
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // IMM_NONE covers R-type and unknown opcodes (immediate reads as 0).
  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_sel_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  function automatic logic [31:0] gen_imm(input logic [31:0] ins, input imm_sel_e sel);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // alt selects SUB/SRA; the caller decides when ins[30] is meaningful.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_pipe_stage_if.sv
// decode_pipe_stage_if: fetch-side, write-back and execute-side signals of
// the decode stage.
//   master : the environment (drives fetch/wb/ex_ready, observes ex_*)
//   slave  : the decode stage itself
interface decode_pipe_stage_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTRUCTION = 32,
  parameter int ALU_CONTROL = 4,
  parameter int NUM_REGS    = 32,
  parameter int RA          = $clog2(NUM_REGS)
);
  logic                   id_valid;
  logic                   id_ready;
  logic [INSTRUCTION-1:0] instruction;
  logic [DATA_WIDTH-1:0]  id_pc;
  logic                   flush;
  logic                   wb_en;
  logic [RA-1:0]          wb_rd;
  logic [DATA_WIDTH-1:0]  wb_data;
  logic                   ex_valid;
  logic                   ex_ready;
  logic [ALU_CONTROL-1:0] ex_alu_control;
  logic [DATA_WIDTH-1:0]  ex_opa;
  logic [DATA_WIDTH-1:0]  ex_opb;
  logic [DATA_WIDTH-1:0]  ex_store_data;
  logic [DATA_WIDTH-1:0]  ex_imm;
  logic [RA-1:0]          ex_rd;
  logic [2:0]             ex_funct3;
  logic                   ex_reg_write;
  logic                   ex_load;
  logic                   ex_store;
  logic                   ex_branch;
  logic                   ex_jump;
  logic                   ex_illegal;
  logic [1:0]             ex_mem_to_reg;

  modport master (
    output id_valid, instruction, id_pc, flush, wb_en, wb_rd, wb_data, ex_ready,
    input  id_ready, ex_valid, ex_alu_control, ex_opa, ex_opb, ex_store_data,
           ex_imm, ex_rd, ex_funct3, ex_reg_write, ex_load, ex_store,
           ex_branch, ex_jump, ex_illegal, ex_mem_to_reg
  );

  modport slave (
    input  id_valid, instruction, id_pc, flush, wb_en, wb_rd, wb_data, ex_ready,
    output id_ready, ex_valid, ex_alu_control, ex_opa, ex_opb, ex_store_data,
           ex_imm, ex_rd, ex_funct3, ex_reg_write, ex_load, ex_store,
           ex_branch, ex_jump, ex_illegal, ex_mem_to_reg
  );
endinterface

// File: rtl/decode_pipe_stage_regfile.sv
// regfile_2r1w: architectural register file, two asynchronous read ports and
// one synchronous write port. x0 always reads 0 and ignores writes; every
// register clears on synchronous rst.
//   clk, rst              clock, synchronous active-high reset
//   we_i/waddr_i/wdata_i  write port
//   raddr1_i/rdata1_o     read port 1 (rs1)
//   raddr2_i/rdata2_o     read port 2 (rs2)
module regfile_2r1w #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RA         = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [RA-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [RA-1:0]         raddr1_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  input  logic [RA-1:0]         raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata2_o
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: RV32I decode stage between fetch and execute. Decodes
// the instruction, reads rs1/rs2 from regfile_2r1w and holds the result in
// the ID/EX register with valid/ready handshakes on both sides.
//   clk, rst  clock, synchronous active-high reset
//   bus       decode_pipe_stage_if.slave (fetch, write-back, execute side)
// Build option DECODE_WB_BYPASS_EN: when defined, write-back data is forwarded
// to the operand reads in the same cycle; otherwise a decode that reads a
// register being written this cycle stalls one cycle.
module decode_pipe_stage
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTRUCTION = 32,
  parameter int ALU_CONTROL = 4,
  parameter int NUM_REGS    = 32,
  parameter int RA          = $clog2(NUM_REGS)
) (
  input logic               clk,
  input logic               rst,
  decode_pipe_stage_if.slave bus
);

  typedef struct packed {
    logic [ALU_CONTROL-1:0] alu_control;
    logic [DATA_WIDTH-1:0]  opa;
    logic [DATA_WIDTH-1:0]  opb;
    logic [DATA_WIDTH-1:0]  store_data;
    logic [DATA_WIDTH-1:0]  imm;
    logic [RA-1:0]          rd;
    logic [2:0]             funct3;
    logic                   reg_write;
    logic                   load;
    logic                   store;
    logic                   branch;
    logic                   jump;
    logic                   illegal;
    logic [1:0]             mem_to_reg;
  } idex_t;

  logic [INSTRUCTION-1:0] ins;
  logic [RA-1:0]          rs1, rs2;
  logic [DATA_WIDTH-1:0]  rf_rs1, rf_rs2, rs1_val, rs2_val;

  imm_sel_e               imm_sel;
  logic                   opa_pc, opa_zero, opb_imm, rs1_used, rs2_used;
  logic                   wb_hazard, load_use, hazard, adv, issue;
  idex_t                  dec;
  idex_t                  idex_d, idex_q;
  logic                   ex_valid_d, ex_valid_q;

  assign ins = bus.instruction;
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];

  regfile_2r1w #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH),
    .RA        (RA)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (bus.wb_en),
    .waddr_i (bus.wb_rd),
    .wdata_i (bus.wb_data),
    .raddr1_i(rs1),
    .rdata1_o(rf_rs1),
    .raddr2_i(rs2),
    .rdata2_o(rf_rs2)
  );

  always_comb begin
    imm_sel         = IMM_NONE;
    opa_pc          = 1'b0;
    opa_zero        = 1'b0;
    opb_imm         = 1'b0;
    rs1_used        = 1'b1;
    rs2_used        = 1'b0;
    dec             = '0;
    dec.funct3      = ins[14:12];
    dec.alu_control = ALU_ADD;
    dec.mem_to_reg  = M2R_ALU;
    case (ins[6:0])
      OPC_LUI: begin
        dec.reg_write = 1'b1;
        imm_sel  = IMM_U;
        opa_zero = 1'b1;
        opb_imm  = 1'b1;
        rs1_used = 1'b0;
      end
      OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        imm_sel  = IMM_U;
        opa_pc   = 1'b1;
        opb_imm  = 1'b1;
        rs1_used = 1'b0;
      end
      OPC_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.mem_to_reg = M2R_PC4;
        imm_sel  = IMM_J;
        opa_pc   = 1'b1;
        opb_imm  = 1'b1;
        rs1_used = 1'b0;
      end
      OPC_JALR: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.mem_to_reg = M2R_PC4;
        imm_sel = IMM_I;
        opb_imm = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        imm_sel    = IMM_B;
        rs2_used   = 1'b1;
        // The ALU produces the compare; the branch unit interprets funct3.
        case (ins[14:12])
          3'b100, 3'b101: dec.alu_control = ALU_SLT;
          3'b110, 3'b111: dec.alu_control = ALU_SLTU;
          default:        dec.alu_control = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.load       = 1'b1;
        dec.mem_to_reg = M2R_MEM;
        imm_sel = IMM_I;
        opb_imm = 1'b1;
      end
      OPC_STORE: begin
        dec.store = 1'b1;
        imm_sel   = IMM_S;
        opb_imm   = 1'b1;
        rs2_used  = 1'b1;
      end
      OPC_OPIMM: begin
        dec.reg_write   = 1'b1;
        imm_sel         = IMM_I;
        opb_imm         = 1'b1;
        // ins[30] only selects SRAI; for ADDI it is part of the immediate.
        dec.alu_control = alu_from_funct3(ins[14:12], (ins[14:12] == 3'b101) && ins[30]);
      end
      OPC_OP: begin
        dec.reg_write   = 1'b1;
        rs2_used        = 1'b1;
        dec.alu_control = alu_from_funct3(ins[14:12], ins[30]);
      end
      default: begin
        dec.illegal = 1'b1;
        rs1_used    = 1'b0;
      end
    endcase
    dec.rd         = dec.reg_write ? ins[11:7] : '0;
    dec.imm        = gen_imm(ins, imm_sel);
    dec.opa        = opa_pc ? bus.id_pc : (opa_zero ? '0 : rs1_val);
    dec.opb        = opb_imm ? dec.imm : rs2_val;
    dec.store_data = rs2_val;
  end

`ifdef DECODE_WB_BYPASS_EN
  assign rs1_val   = (bus.wb_en && (bus.wb_rd == rs1) && (rs1 != '0)) ? bus.wb_data : rf_rs1;
  assign rs2_val   = (bus.wb_en && (bus.wb_rd == rs2) && (rs2 != '0)) ? bus.wb_data : rf_rs2;
  assign wb_hazard = 1'b0;
`else
  assign rs1_val   = rf_rs1;
  assign rs2_val   = rf_rs2;
  // The write lands at this edge, so the reread next cycle sees it.
  assign wb_hazard = bus.wb_en && (bus.wb_rd != '0) &&
                     ((rs1_used && (bus.wb_rd == rs1)) || (rs2_used && (bus.wb_rd == rs2)));
`endif

  assign load_use = ex_valid_q && idex_q.load && (idex_q.rd != '0) &&
                    ((rs1_used && (rs1 == idex_q.rd)) || (rs2_used && (rs2 == idex_q.rd)));
  assign hazard   = load_use || wb_hazard;
  assign adv      = !ex_valid_q || bus.ex_ready;
  assign issue    = bus.id_valid && !hazard;

  assign bus.id_ready = !rst && adv && !hazard && !bus.flush;

  always_comb begin
    idex_d     = idex_q;
    ex_valid_d = ex_valid_q;
    if (bus.flush) begin
      idex_d     = '0;
      ex_valid_d = 1'b0;
    end else if (adv) begin
      idex_d     = issue ? dec : '0;
      ex_valid_d = issue;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q     <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      idex_q     <= idex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign bus.ex_valid       = ex_valid_q;
  assign bus.ex_alu_control = idex_q.alu_control;
  assign bus.ex_opa         = idex_q.opa;
  assign bus.ex_opb         = idex_q.opb;
  assign bus.ex_store_data  = idex_q.store_data;
  assign bus.ex_imm         = idex_q.imm;
  assign bus.ex_rd          = idex_q.rd;
  assign bus.ex_funct3      = idex_q.funct3;
  assign bus.ex_reg_write   = idex_q.reg_write;
  assign bus.ex_load        = idex_q.load;
  assign bus.ex_store       = idex_q.store;
  assign bus.ex_branch      = idex_q.branch;
  assign bus.ex_jump        = idex_q.jump;
  assign bus.ex_illegal     = idex_q.illegal;
  assign bus.ex_mem_to_reg  = idex_q.mem_to_reg;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage. Expected ID/EX contents are pushed to
// a queue when an instruction is accepted and compared when execute consumes it.
module tb_decode_pipe_stage;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_pipe_stage_if bus ();

  decode_pipe_stage dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] sd;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw, ld, st, br, jp, il;
    logic [1:0]  m2r;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  exp_t  pend;
  string ptag;
  int    n_err = 0;
  int    n_chk = 0;
  logic  rdy_s;

  function automatic exp_t observe();
    exp_t o;
    o.alu = bus.ex_alu_control; o.opa = bus.ex_opa; o.opb = bus.ex_opb;
    o.sd  = bus.ex_store_data;  o.imm = bus.ex_imm; o.rd  = bus.ex_rd;
    o.f3  = bus.ex_funct3;      o.rw  = bus.ex_reg_write; o.ld = bus.ex_load;
    o.st  = bus.ex_store;       o.br  = bus.ex_branch;    o.jp = bus.ex_jump;
    o.il  = bus.ex_illegal;     o.m2r = bus.ex_mem_to_reg;
    return o;
  endfunction

  function automatic exp_t mk(input logic [3:0] alu, input logic [31:0] opa, input logic [31:0] opb,
                              input logic [31:0] sd, input logic [31:0] imm, input logic [4:0] rd,
                              input logic [2:0] f3, input logic rw, input logic ld, input logic st,
                              input logic br, input logic jp, input logic il, input logic [1:0] m2r);
    exp_t e;
    e.alu = alu; e.opa = opa; e.opb = opb; e.sd = sd; e.imm = imm; e.rd = rd; e.f3 = f3;
    e.rw = rw; e.ld = ld; e.st = st; e.br = br; e.jp = jp; e.il = il; e.m2r = m2r;
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ex(input string tag, input exp_t obs, input exp_t exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input exp_t e, input string t);
    bus.id_valid    = 1'b1;
    bus.instruction = ins;
    bus.id_pc       = pc;
    pend            = e;
    ptag            = t;
  endtask

  // Entered 1 time unit after a rising edge with inputs driven; samples the
  // handshakes mid-cycle, then returns 1 time unit after the next edge.
  task automatic step();
    exp_t  e;
    string t;
    #1;
    rdy_s = bus.id_ready;
    if (bus.ex_valid && bus.ex_ready) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $error("FAIL sb_underflow observed=output expected=none");
      end else begin
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        chk_ex({"sb_", t}, observe(), e);
      end
    end else if (bus.flush && bus.ex_valid && sb_q.size() > 0) begin
      void'(sb_q.pop_front());
      void'(tag_q.pop_front());
    end
    if (bus.id_valid && bus.id_ready) begin
      sb_q.push_back(pend);
      tag_q.push_back(ptag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = rd;
    bus.wb_data = data;
    step();
    bus.wb_en   = 1'b0;
  endtask

  exp_t e_addi13;

  initial begin
    bus.id_valid = 1'b0; bus.instruction = '0; bus.id_pc = '0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; bus.ex_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk32("rst_id_ready", 32'(bus.id_ready), 32'd0);
    chk32("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk_ex("rst_ex_fields", observe(), '0);
    rst = 1'b0;
    #1;
    chk32("post_rst_id_ready", 32'(bus.id_ready), 32'd1);

    wb_write(5'd6, 32'h123);
    wb_write(5'd7, 32'h0F0);

    // ADDI x1,x0,5
    drive(enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPC_OPIMM), 32'h0,
          mk(ALU_ADD, 0, 5, 0, 5, 1, 0, 1, 0, 0, 0, 0, 0, M2R_ALU), "addi");
    step();
    chk32("addi_accept", 32'(rdy_s), 32'd1);
    chk32("addi_ex_valid", 32'(bus.ex_valid), 32'd1);
    chk32("addi_opb", bus.ex_opb, 32'd5);

    // ADD x8,x6,x7 and SUB x9,x6,x7
    drive(enc_r(7'h00, 5'd7, 5'd6, 3'd0, 5'd8), 32'h4,
          mk(ALU_ADD, 32'h123, 32'hF0, 32'hF0, 0, 8, 0, 1, 0, 0, 0, 0, 0, M2R_ALU), "add");
    step();
    drive(enc_r(7'h20, 5'd7, 5'd6, 3'd0, 5'd9), 32'h8,
          mk(ALU_SUB, 32'h123, 32'hF0, 32'hF0, 0, 9, 0, 1, 0, 0, 0, 0, 0, M2R_ALU), "sub");
    step();

    // LW x2,0(x1) then dependent ADD x3,x2,x1: one stall, one bubble
    drive(enc_i(12'd0, 5'd1, 3'b010, 5'd2, OPC_LOAD), 32'hC,
          mk(ALU_ADD, 0, 0, 0, 0, 2, 3'b010, 1, 1, 0, 0, 0, 0, M2R_MEM), "lw");
    step();
    drive(enc_r(7'h00, 5'd1, 5'd2, 3'd0, 5'd3), 32'h10,
          mk(ALU_ADD, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, M2R_ALU), "add_dep");
    step();
    chk32("loaduse_id_ready", 32'(rdy_s), 32'd0);
    chk32("loaduse_bubble", 32'(bus.ex_valid), 32'd0);
    step();
    chk32("loaduse_issue", 32'(rdy_s), 32'd1);
    chk32("loaduse_dep_valid", 32'(bus.ex_valid), 32'd1);

    // load to x0 never interlocks
    drive(enc_i(12'd0, 5'd0, 3'b010, 5'd0, OPC_LOAD), 32'h14,
          mk(ALU_ADD, 0, 0, 0, 0, 0, 3'b010, 1, 1, 0, 0, 0, 0, M2R_MEM), "lw_x0");
    step();
    drive(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd15), 32'h18,
          mk(ALU_ADD, 0, 0, 0, 0, 15, 0, 1, 0, 0, 0, 0, 0, M2R_ALU), "add_x0");
    step();
    chk32("lw_x0_no_hazard", 32'(rdy_s), 32'd1);

    // SW x7,12(x6)
    drive(enc_s(12'd12, 5'd7, 5'd6, 3'b010), 32'h1C,
          mk(ALU_ADD, 32'h123, 12, 32'hF0, 12, 0, 3'b010, 0, 0, 1, 0, 0, 0, M2R_ALU), "sw");
    step();
    // BEQ x6,x7,-8
    drive(enc_b(13'h1FF8, 5'd7, 5'd6, 3'd0), 32'h20,
          mk(ALU_SUB, 32'h123, 32'hF0, 32'hF0, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 1, 0, 0, M2R_ALU), "beq");
    step();
    chk32("beq_imm", bus.ex_imm, 32'hFFFF_FFF8);
    chk32("beq_branch", 32'(bus.ex_branch), 32'd1);
    // LUI x10,0x12345
    drive(enc_u(20'h12345, 5'd10, OPC_LUI), 32'h24,
          mk(ALU_ADD, 0, 32'h1234_5000, 0, 32'h1234_5000, 10, 3'd5, 1, 0, 0, 0, 0, 0, M2R_ALU), "lui");
    step();
    // AUIPC x11,0x1 at pc 0x100
    drive(enc_u(20'h00001, 5'd11, OPC_AUIPC), 32'h100,
          mk(ALU_ADD, 32'h100, 32'h1000, 0, 32'h1000, 11, 3'd1, 1, 0, 0, 0, 0, 0, M2R_ALU), "auipc");
    step();
    // JAL x1,+16 at pc 0x200
    drive(enc_j(21'd16, 5'd1), 32'h200,
          mk(ALU_ADD, 32'h200, 16, 0, 16, 1, 0, 1, 0, 0, 0, 1, 0, M2R_PC4), "jal");
    step();
    // JALR x1,4(x6)
    drive(enc_i(12'd4, 5'd6, 3'd0, 5'd1, OPC_JALR), 32'h204,
          mk(ALU_ADD, 32'h123, 4, 0, 4, 1, 0, 1, 0, 0, 0, 1, 0, M2R_PC4), "jalr");
    step();
    // unknown opcode
    drive(32'h0000_007F, 32'h208,
          mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, M2R_ALU), "illegal");
    step();
    bus.id_valid = 1'b0;
    step();
    chk32("illegal_flag", 32'(bus.ex_illegal), 32'd0);

    // write to x0 is dropped
    wb_write(5'd0, 32'hDEAD);
    drive(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd12), 32'h20C,
          mk(ALU_ADD, 0, 0, 0, 0, 12, 0, 1, 0, 0, 0, 0, 0, M2R_ALU), "add_x0w");
    step();
    chk32("x0_reads_zero", bus.ex_opa, 32'd0);

    // same-cycle write-back to x4 with ADD x5,x4,x0
    bus.wb_en = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'hABCD;
    drive(enc_r(7'h00, 5'd0, 5'd4, 3'd0, 5'd5), 32'h210,
          mk(ALU_ADD, 32'hABCD, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, M2R_ALU), "add_wb");
`ifdef DECODE_WB_BYPASS_EN
    step();
    chk32("bypass_id_ready", 32'(rdy_s), 32'd1);
    bus.wb_en = 1'b0;
`else
    step();
    chk32("wbstall_id_ready", 32'(rdy_s), 32'd0);
    bus.wb_en = 1'b0;
    step();
    chk32("wbstall_retry_id_ready", 32'(rdy_s), 32'd1);
`endif
    chk32("wb_opa", bus.ex_opa, 32'hABCD);

    // back-pressure then flush
    e_addi13 = mk(ALU_ADD, 0, 7, 32'hF0, 7, 13, 0, 1, 0, 0, 0, 0, 0, M2R_ALU);
    drive(enc_i(12'd7, 5'd0, 3'd0, 5'd13, OPC_OPIMM), 32'h214, e_addi13, "addi13");
    step();
    bus.ex_ready = 1'b0;
    drive(enc_i(12'd9, 5'd0, 3'd0, 5'd14, OPC_OPIMM), 32'h218,
          mk(ALU_ADD, 0, 9, 0, 9, 14, 0, 1, 0, 0, 0, 0, 0, M2R_ALU), "addi14");
    for (int i = 0; i < 3; i++) begin
      step();
      chk32("stall_id_ready", 32'(rdy_s), 32'd0);
      chk32("stall_ex_valid", 32'(bus.ex_valid), 32'd1);
      chk_ex("stall_hold", observe(), e_addi13);
    end
    bus.flush = 1'b1;
    step();
    chk32("flush_id_ready", 32'(rdy_s), 32'd0);
    chk32("flush_ex_valid", 32'(bus.ex_valid), 32'd0);
    bus.flush = 1'b0;
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b1;
    step();
    step();
    chk32("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_pipe_stage.md
# decode_pipe_stage

Pipelined RV32I decode stage: decodes all base formats (R/I/load/S/B/U/J), reads a 2R1W register file with write-back port, and holds results in an ID/EX pipeline register with valid/ready handshakes on both sides. Sits between fetch and execute. Adds load-use interlock, flush, and same-cycle write-back bypass over the previous single-cycle decoder.

## Interface
- DATA_WIDTH, 32, register/operand width
- INSTRUCTION, 32, instruction width
- ALU_CONTROL, 4, ALU control code width
- NUM_REGS, 32, architectural registers; address width RA = $clog2(NUM_REGS)

Clock and reset: one clock; reset is synchronous and active-high.

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  instruction/pc valid from fetch
- id_ready  out  1  decode accepts this cycle
- instruction  in  INSTRUCTION  instruction word
- id_pc  in  DATA_WIDTH  instruction address
- flush  in  1  kill ID/EX contents and the current input
- wb_en  in  1  write-back enable
- wb_rd  in  RA  write-back destination
- wb_data  in  DATA_WIDTH  write-back data
- ex_valid  out  1  ID/EX register holds an instruction
- ex_ready  in  1  execute consumes ID/EX this cycle
- ex_alu_control  out  ALU_CONTROL  ALU operation
- ex_opa / ex_opb  out  DATA_WIDTH  ALU operands
- ex_store_data  out  DATA_WIDTH  rs2 value for stores
- ex_imm  out  DATA_WIDTH  sign-extended immediate
- ex_rd  out  RA  destination register
- ex_funct3  out  3  funct3 for memory size / branch compare
- ex_reg_write, ex_load, ex_store, ex_branch, ex_jump, ex_illegal  out  1 each  control flags
- ex_mem_to_reg  out  2  write-back source (00 ALU, 01 memory, 10 pc+4)

## Operation
- Advance condition: adv = !ex_valid || ex_ready. id_ready = adv && !hazard && !flush.
- On adv: ex_valid <= id_valid && !hazard && !flush; control fields load from decode; if bubble, all control flags load 0.
- hazard (load-use): ex_valid && ex_load && ex_rd != 0 && ((rs1 used && rs1 == ex_rd) || (rs2 used && rs2 == ex_rd)). rs1 unused for LUI/AUIPC/JAL; rs2 used only for R, S, B.
- Immediates: I = sext(ins[31:20]); S = sext({ins[31:25],ins[11:7]}); B = sext({ins[31],ins[7],ins[30:25],ins[11:8],0}); U = {ins[31:12],12'b0}; J = sext({ins[31],ins[19:12],ins[20],ins[30:21],0}).
- ex_opa: id_pc for AUIPC/JAL, 0 for LUI, rs1 value otherwise. ex_opb: immediate for I/load/S/U/J/JALR, rs2 value for R/B.
- Unknown opcode: ex_illegal=1, ex_reg_write/ex_load/ex_store/ex_branch/ex_jump=0.
- Register file: x0 reads 0, writes to x0 ignored; all registers cleared on rst.

## Timing
- Decode-to-ex latency: 1 cycle after id_valid && id_ready.
- Reset: ex_valid=0, all ex_* outputs 0, id_ready=0 during rst, 1 the cycle after.
- flush priority: rst > flush > hazard > normal. flush clears ex_valid next cycle regardless of ex_ready; input is dropped.
- Hazard lasts exactly while the load occupies ID/EX; once it advances, a bubble follows and the dependent instruction issues the next cycle.
- ex_ready=0 with ex_valid=1: all ex_* hold, id_ready=0.
- wb_en to register visible to a reading decode the following cycle without bypass.

## Configuration
- DECODE_WB_BYPASS_EN defined: wb_data forwarded combinationally to rs1/rs2 read when wb_en && wb_rd == rs && rs != 0 (same-cycle write/read returns new value).
- Undefined: no forwarding; hazard additionally asserts when wb_en && wb_rd != 0 matches a used rs, stalling one cycle.

## Structure
- Package decode_pkg: opcode localparams, imm_sel enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J), ALU control codes, mem_to_reg codes.
- Sub-module regfile_2r1w (NUM_REGS, DATA_WIDTH; sync reset, async read). Decode logic and ID/EX register in top.

## Test plan
- Reset, then ADDI x1,x0,5 with ex_ready=1 -> next cycle ex_valid=1, ex_opa=0, ex_opb=5, ex_reg_write=1, ex_rd=1.
- LW x2,0(x1) then ADD x3,x2,x1 -> id_ready=0 one cycle, one bubble (ex_valid=0), ADD issues next cycle.
- BEQ with offset -8 -> ex_imm=32'hFFFF_FFF8, ex_branch=1, ex_reg_write=0.
- wb_en=1,wb_rd=4,wb_data=0xABCD with ADD x5,x4,x0 same cycle -> bypass: ex_opa=0xABCD; without macro: one-cycle stall then 0xABCD.
- ex_ready=0 held 3 cycles -> ex_* stable, id_ready=0; flush -> ex_valid=0 next cycle.
- Opcode 7'b1111111 -> ex_illegal=1, all write/memory flags 0; write to x0 -> reads stay 0.
